uart_receiver: RTL
==================

Name: uart_receiver

Overview:
Serial receive stage downstream of the existing UART transmitter; it consumes the TxD line (looped back or external) on its RxD input. Recovers 8N1 frames (8E1 with parity option) using a per-bit clock-divider counter with mid-bit sampling. Delivers each byte on a held parallel register with a one-cycle valid strobe, for the 7-segment and display logic. Single clock domain; RxD is asynchronous and synchronised internally.

Parameters:
CLKS_PER_BIT, 10416, clk cycles per bit period (100 MHz / 9600 baud); legal range 4..65535.

Ports:
clk  input  1  system clock; all logic rising-edge.
rst  input  1  synchronous, active-high reset.
RxD  input  1  asynchronous serial line; idle high.
data  output  8  last good received byte, LSB first on the line; held until the next good frame.
data_valid  output  1  one-cycle pulse; data updated this cycle.
framing_error  output  1  one-cycle pulse; stop bit sampled low.
busy  output  1  high whenever state != IDLE.
parity_error  output  1  one-cycle pulse; present only with UART_RX_PARITY_EN.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, counters=0, data=8'h00, data_valid=0, framing_error=0, parity_error=0, busy=0, synchroniser flops=1. Applies mid-frame; the partial frame is discarded with no pulse.
- RxD passes through a 2-flop synchroniser to give rx_s. All decisions use rx_s only.
- Bit counter cnt is 16 bits and counts 0..CLKS_PER_BIT-1. The bit index is 3 bits.
- IDLE: when rx_s==0, go to START with cnt=0.
- START: at cnt==CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
  - rx_s==0: go to DATA with cnt=0 and bit index=0.
  - rx_s==1: glitch; return to IDLE with no pulse.
- DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into the shift register MSB (right shift, so LSB arrives first), set cnt=0, and increment the bit index. After bit 7 go to STOP (or PARITY if enabled).
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1: data<=shift register; data_valid=1 for exactly one cycle (registered, the cycle after the sample edge). Go to IDLE.
  - rx_s==0: framing_error=1 for one cycle; data unchanged. Go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. This stops a held-low line from re-triggering a start.
- Re-arming: IDLE is re-entered half a bit before the nominal stop end, so a start edge immediately after the stop bit is caught. Back-to-back frames with no idle gap are received.
- Pulses never coincide: data_valid, framing_error and parity_error are mutually exclusive per frame.
- Latency: from the RxD falling edge, data_valid rises about 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles later, ±1 for synchroniser phase.
- Outputs are all registered; there are no combinational paths from RxD.

Optional Feature:
UART_RX_PARITY_EN
- Defined: frame is 8E1. A PARITY state follows DATA and samples at cnt==CLKS_PER_BIT-1.
  - Good parity and good stop: data_valid pulse.
  - Parity mismatch with good stop: parity_error pulse instead; data unchanged.
  - Bad stop: framing_error takes priority over parity_error.
  - parity_error port exists.
- Undefined: 8N1 frame, no PARITY state, and the parity_error port is absent.

Test Plan:
1. CLKS_PER_BIT=16: send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> data=8'hA5; data_valid high exactly 1 cycle about 155 cycles after the start edge; busy low afterwards.
2. CLKS_PER_BIT=16: RxD low for 4 cycles then high -> no pulse of any kind; busy returns to 0 within 10 cycles; data unchanged.
3. Send 0x3C, then a frame for 0x99 with a low stop bit held low for 40 cycles -> frame 1 gives data=8'h3C with valid. Frame 2 gives one framing_error pulse, data stays 8'h3C, and no new start is detected until RxD returns high.
4. Back-to-back 0x00 then 0xFF with zero idle gap -> two data_valid pulses 160±1 cycles apart, with data 8'h00 then 8'hFF.
5. Assert rst for 1 cycle during bit 4 of a frame, then send 0x5A cleanly -> outputs zero after reset; next frame yields 8'h5A with exactly one valid.
6. (UART_RX_PARITY_EN) Send 0x07 with parity bit 0 -> parity_error pulse, no data_valid, data unchanged. Send 0x07 with parity bit 1 -> data_valid with data=8'h07.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receiver: 8N1 frames with mid-bit sampling, held byte output and one-cycle strobes.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_error strobe.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_error
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_MID = 16'(CLKS_PER_BIT / 2 - 1);

    logic        rx_meta_q;
    logic        rx_s_q;

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic        framing_error_q, framing_error_d;
    logic        busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic        par_bad_q, par_bad_d;
    logic        parity_error_q, parity_error_d;
`endif

    logic cnt_end;
    logic cnt_mid;

    assign cnt_end = (cnt_q == CNT_MAX);
    assign cnt_mid = (cnt_q == CNT_MID);

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RxD;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q + 16'd1;
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        data_d          = data_q;
        data_valid_d    = 1'b0;
        framing_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d       = par_bad_q;
        parity_error_d  = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_mid) begin
                    cnt_d = 16'd0;
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (cnt_end) begin
                    cnt_d     = 16'd0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_end) begin
                    cnt_d     = 16'd0;
                    par_bad_d = rx_s_q ^ (^shift_q);
                    state_d   = S_STOP;
                end
            end
`endif

            // Leaving at mid stop bit re-arms half a bit early for back-to-back frames.
            S_STOP: begin
                if (cnt_end) begin
                    cnt_d = 16'd0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            parity_error_d = 1'b1;
                        end else begin
                            data_d       = shift_q;
                            data_valid_d = 1'b1;
                        end
`else
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
`endif
                    end else begin
                        framing_error_d = 1'b1;
                        state_d         = S_BREAK;
                    end
                end
            end

            S_BREAK: begin
                cnt_d = 16'd0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                cnt_d   = 16'd0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= 16'd0;
            bit_idx_q       <= 3'd0;
            shift_q         <= 8'h00;
            data_q          <= 8'h00;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            data_q          <= data_d;
            data_valid_q    <= data_valid_d;
            framing_error_q <= framing_error_d;
            busy_q          <= busy_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad_q      <= 1'b0;
            parity_error_q <= 1'b0;
        end else begin
            par_bad_q      <= par_bad_d;
            parity_error_q <= parity_error_d;
        end
    end

    assign parity_error = parity_error_q;
`endif

    assign data          = data_q;
    assign data_valid    = data_valid_q;
    assign framing_error = framing_error_q;
    assign busy          = busy_q;

endmodule
